// File: rtl/ram_fifo.sv
// First-word fall-through FIFO on a 2**DEPTH x WIDTH register-array RAM.
// Optional occupancy output enabled by defining RAM_FIFO_FILL_LEVEL_EN.
module ram_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
`ifdef RAM_FIFO_FILL_LEVEL_EN
  output logic [DEPTH:0]   fill_level,
`endif
  output logic             empty
);

  localparam logic [DEPTH-1:0] PTR_ONE  = DEPTH'(1);
  localparam logic [DEPTH-1:0] PTR_ZERO = {DEPTH{1'b0}};
  localparam logic [DEPTH:0]   CNT_ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   CNT_ZERO = {(DEPTH+1){1'b0}};
  localparam logic [DEPTH:0]   CAPACITY = {1'b1, {DEPTH{1'b0}}};

  logic [WIDTH-1:0] mem_r [2**DEPTH];
  logic [DEPTH-1:0] wr_ptr_r;
  logic [DEPTH-1:0] rd_ptr_r;
  logic [DEPTH:0]   count_r;
  logic [DEPTH:0]   count_nxt_s;
  logic             do_write_s;
  logic             do_read_s;

  assign full  = (count_r == CAPACITY);
  assign empty = (count_r == CNT_ZERO);

  // A pop while full frees a slot in the same edge, so the write may proceed.
  assign do_write_s = shift_in & (~full | shift_out);
  assign do_read_s  = shift_out & ~empty;

  assign rdata = mem_r[rd_ptr_r];

`ifdef RAM_FIFO_FILL_LEVEL_EN
  assign fill_level = count_r;
`endif

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({do_write_s, do_read_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_read_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

  // RAM array; contents are intentionally left untouched by reset.
  always_ff @(posedge clk) begin
    if (res_n && do_write_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo: randomized data against a queue model.
module tb_ram_fifo;

  localparam int CAP = 256;

  logic       clk;
  logic       res_n;
  logic       shift_in;
  logic       shift_out;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
`ifdef RAM_FIFO_FILL_LEVEL_EN
  logic [8:0] fill_level;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q[$];

  ram_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk),
    .res_n(res_n),
    .shift_in(shift_in),
    .shift_out(shift_out),
    .wdata(wdata),
    .rdata(rdata),
    .full(full),
`ifdef RAM_FIFO_FILL_LEVEL_EN
    .fill_level(fill_level),
`endif
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle on the falling edge, update the model at the rising edge.
  task automatic step(input logic si, input logic so, input logic [7:0] d);
    bit wr, rd;
    @(negedge clk);
    res_n = 1'b1; shift_in = si; shift_out = so; wdata = d;
    @(posedge clk);
    rd = so && (q.size() > 0);
    wr = si && ((q.size() < CAP) || so);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(d);
    #1;
  endtask

  // Hold reset with both requests active to prove reset dominates.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    res_n = 1'b0; shift_in = 1'b1; shift_out = 1'b1; wdata = 8'($urandom);
    repeat (cycles) @(posedge clk);
    q.delete();
    #1;
  endtask

  task automatic test_reset();
    do_reset(10);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
`ifdef RAM_FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill_level !== 9'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", fill_level); end
`endif
    step(1'b0, 1'b1, 8'h00);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL read_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL read_empty_full got=%b exp=0", full); end
  endtask

  task automatic test_fill();
    logic [7:0] head;
    for (int i = 0; i < CAP; i++) begin
      step(1'b1, 1'b0, 8'($urandom));
      n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
      n_cmp++; if (full !== (i == CAP - 1)) begin n_bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == CAP - 1)); end
      n_cmp++; if (rdata !== q[0]) begin n_bad++; $display("FAIL fill_head i=%0d got=%h exp=%h", i, rdata, q[0]); end
    end
    head = q[0];
    step(1'b1, 1'b0, ~head);
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL overflow_full got=%b exp=1", full); end
    n_cmp++; if (rdata !== head) begin n_bad++; $display("FAIL overflow_head got=%h exp=%h", rdata, head); end
`ifdef RAM_FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill_level !== 9'd256) begin n_bad++; $display("FAIL full_level got=%0d exp=256", fill_level); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < CAP; i++) begin
      n_cmp++; if (rdata !== q[0]) begin n_bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, rdata, q[0]); end
      step(1'b0, 1'b1, 8'h00);
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL drain_full i=%0d got=%b exp=0", i, full); end
      n_cmp++; if (empty !== (i == CAP - 1)) begin n_bad++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, empty, (i == CAP - 1)); end
    end
  endtask

  task automatic test_streaming();
    logic [7:0] d;
    do_reset(1);
    for (int i = 0; i < CAP; i++) begin
      d = 8'($urandom);
      step(1'b1, 1'b1, d);
      n_cmp++; if (empty !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL stream_flags i=%0d got=%b%b exp=00", i, empty, full); end
      n_cmp++; if (rdata !== d) begin n_bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, rdata, d); end
`ifdef RAM_FIFO_FILL_LEVEL_EN
      n_cmp++; if (fill_level !== 9'd1) begin n_bad++; $display("FAIL stream_level i=%0d got=%0d exp=1", i, fill_level); end
`endif
    end
    step(1'b0, 1'b1, 8'h00);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL stream_end got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 32; i++) begin
        step(1'b1, 1'b0, 8'($urandom));
        n_cmp++; if (empty !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL wrap_fill r=%0d i=%0d got=%b%b exp=00", r, i, empty, full); end
      end
      for (int i = 0; i < 32; i++) begin
        n_cmp++; if (rdata !== q[0]) begin n_bad++; $display("FAIL wrap_data r=%0d i=%0d got=%h exp=%h", r, i, rdata, q[0]); end
        step(1'b0, 1'b1, 8'h00);
      end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty r=%0d got=%b exp=1", r, empty); end
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] old_head;
    do_reset(1);
    for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      old_head = q[0];
      step(1'b1, 1'b1, 8'($urandom));
      n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_rw_full i=%0d got=%b exp=1", i, full); end
      n_cmp++; if (rdata !== q[0] || q[0] === old_head && rdata === old_head && q.size() != CAP)
        begin n_bad++; $display("FAIL full_rw_head i=%0d got=%h exp=%h", i, rdata, q[0]); end
    end
    for (int i = 0; i < CAP; i++) begin
      n_cmp++; if (rdata !== q[0]) begin n_bad++; $display("FAIL full_rw_drain i=%0d got=%h exp=%h", i, rdata, q[0]); end
      step(1'b0, 1'b1, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 8'($urandom));
    do_reset(1);
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL mid_reset got=%b%b exp=10", empty, full); end
    step(1'b0, 1'b1, 8'h00);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_reset_pop got=%b exp=1", empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45), 8'($urandom));
      n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == CAP))
        begin n_bad++; $display("FAIL rand_flags i=%0d got=%b%b exp=%b%b", i, empty, full, (q.size() == 0), (q.size() == CAP)); end
      if (q.size() > 0) begin
        n_cmp++; if (rdata !== q[0]) begin n_bad++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, rdata, q[0]); end
      end
`ifdef RAM_FIFO_FILL_LEVEL_EN
      n_cmp++; if (fill_level !== 9'(q.size())) begin n_bad++; $display("FAIL rand_level i=%0d got=%0d exp=%0d", i, fill_level, q.size()); end
`endif
    end
  endtask

  initial begin
    res_n = 1'b0; shift_in = 1'b0; shift_out = 1'b0; wdata = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_wrap();
    test_full_rw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo.md
RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, the address width; capacity is 2**DEPTH words (256 by default).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port res_n, input, 1 bit, the reset; synchronous, active-low.
REQ-005 The block SHALL have port shift_in, input, 1 bit, the write request; it writes wdata at the rising edge.
REQ-006 The block SHALL have port shift_out, input, 1 bit, the read request; it pops the oldest word at the rising edge.
REQ-007 The block SHALL have port wdata, input, WIDTH bits, the write data.
REQ-008 The block SHALL have port rdata, output, WIDTH bits, the oldest stored word (first-word fall-through).
REQ-009 The block SHALL have port full, output, 1 bit, high when 2**DEPTH words are stored.
REQ-010 The block SHALL have port empty, output, 1 bit, high when 0 words are stored.

Function
REQ-011 Storage SHALL be a 2**DEPTH x WIDTH register-array RAM with DEPTH-bit write and read pointers.
REQ-012 An occupancy count of DEPTH+1 bits SHALL be kept, or equivalent extra pointer wrap bits.
REQ-013 full and empty SHALL be derived combinationally from the occupancy state.
REQ-014 A write SHALL occur when shift_in=1 and (full=0 or shift_out=1).
REQ-015 On a write, mem[wr_ptr] SHALL be set to wdata and wr_ptr SHALL increment.
REQ-016 A read SHALL occur when shift_out=1 and empty=0.
REQ-017 On a read, rd_ptr SHALL increment.
REQ-018 rdata SHALL equal mem[rd_ptr] combinationally, so the head word is valid in the same cycle empty=0 and there is no read latency.
REQ-019 rdata SHALL be don't-care while empty=1.
REQ-020 A word written at edge N SHALL make empty=0 and be on rdata after edge N.
REQ-021 Pointers SHALL wrap from 2**DEPTH-1 to 0.
REQ-022 Write only SHALL increase the count by 1; read only SHALL decrease it by 1.
REQ-023 A simultaneous read and write SHALL leave the count unchanged.
REQ-024 shift_in while full with shift_out=0 SHALL be ignored: no pointer, data or flag change.
REQ-025 shift_out while empty SHALL be ignored.
REQ-026 shift_in=1 and shift_out=1 while empty SHALL perform the write only, giving count 1.
REQ-027 shift_in=1 and shift_out=1 while full SHALL perform both, with the count staying 2**DEPTH.
REQ-028 full and empty SHALL never be high together.

Reset
REQ-029 At a rising edge with res_n=0, pointers and count SHALL clear: empty=1, full=0.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 Reset SHALL override any simultaneous shift_in or shift_out.
REQ-032 A reset mid-operation SHALL discard all stored words.

Configuration
REQ-033 With macro RAM_FIFO_FILL_LEVEL_EN defined, the block SHALL add output fill_level, DEPTH+1 bits, equal to the current occupancy (0 at reset, 2**DEPTH when full).
REQ-034 Without RAM_FIFO_FILL_LEVEL_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
Bench uses WIDTH=8, DEPTH=8 and a 10-unit clock; stimulus changes on the falling edge.
REQ-035 Reset: hold res_n=0 for 10 cycles, then release -> empty=1, full=0; shift_out while empty leaves empty=1.
REQ-036 Fill: 256 consecutive writes of random data -> empty=0 after the first, full=1 exactly after the 256th; a 257th write is ignored.
REQ-037 Drain: assert shift_out until empty -> rdata sequence matches the write order exactly; empty=1 after the 256th read; full drops after the first read.
REQ-038 Streaming: from empty, 256 cycles of shift_in=1 and shift_out=1 -> first cycle writes only; count stays 1 thereafter; rdata equals the word written the previous cycle.
REQ-039 Wrap: fill 32, drain all, repeat 10 times -> data order is preserved across pointer wrap; flags are correct at each boundary.
REQ-040 Full plus simultaneous read/write: with the FIFO full, shift_in=1 and shift_out=1 -> full stays 1 and the oldest word is popped. Reset asserted mid-fill at count 100 -> empty=1 at the next edge.
